tick_gen: RTL and testbench

Programmable, runtime-reconfigurable successor to the fixed slow-clock divider. It generates a slow square wave, a periodic single-cycle tick, or a retriggerable one-shot delay from the system clock. The half-period is loadable at run time, and counting can be gated by an enable. It sits beside the display and UI logic and drives blink rates, debounce windows, sample strobes and timeouts in the order of milliseconds to seconds.

---
 rtl/tick_gen.sv | 121 ++++++++++++
 tb/tb_tick_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen.sv
// tick_gen: programmable slow-clock / tick / one-shot generator.
// Everything is derived from one up-counter that is compared against a
// run-time loadable period register. All outputs are registered.

module tick_gen #(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] DEFAULT_TICKS = 49_999_999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             period_load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             start,
    output logic             slow_clk,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0]       MODE_PULSE   = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH-1:0] ONE          = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic             slow_d;
    logic             tick_d;
    logic             busy_d;
    logic             done_d;

    logic             is_oneshot;
    logic             is_square;
    logic             at_event;

    // Reserved mode 11 falls into the square-wave behaviour.
    assign is_oneshot = (mode_q == MODE_ONESHOT);
    assign is_square  = (mode_q != MODE_PULSE) && (mode_q != MODE_ONESHOT);
    assign at_event   = (count_q == p_q);

    // Next-state logic: load beats mode change, which beats start, which beats counting.
    always_comb begin
        p_d     = p_q;
        count_d = count_q;
        mode_d  = mode_q;
        state_d = state_q;
        slow_d  = slow_clk;
        tick_d  = 1'b0;
        busy_d  = busy;
        done_d  = done;

        if (period_load) begin
            p_d     = period_in;
            count_d = '0;
        end else if (mode != mode_q) begin
            mode_d  = mode;
            count_d = '0;
            slow_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = (mode == MODE_ONESHOT) ? IDLE : RUN;
        end else if (start && is_oneshot) begin
            count_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = RUN;
        end else if (enable && (state_q == RUN)) begin
            if (at_event) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (is_square) begin
                    slow_d = ~slow_clk;
                end
                if (is_oneshot) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    // State and output registers; reset picks the initial state from the live mode input.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_q      <= DEFAULT_TICKS;
            count_q  <= '0;
            mode_q   <= mode;
            state_q  <= (mode == MODE_ONESHOT) ? IDLE : RUN;
            slow_clk <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            p_q      <= p_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            state_q  <= state_d;
            slow_clk <= slow_d;
            tick     <= tick_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: scoreboard bench for tick_gen. Each driven cycle pushes the
// expected post-edge outputs from a reference model into a queue; an
// independent monitor pops and compares after every clock edge.

module tb_tick_gen;

    localparam int unsigned      WIDTH = 32;
    localparam logic [WIDTH-1:0] DEF_P = 32'd3;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic             period_load;
    logic [WIDTH-1:0] period_in;
    logic             start;
    logic             slow_clk;
    logic             tick;
    logic             busy;
    logic             done;

    tick_gen #(
        .WIDTH        (WIDTH),
        .DEFAULT_TICKS(DEF_P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .period_load(period_load),
        .period_in  (period_in),
        .start      (start),
        .slow_clk   (slow_clk),
        .tick       (tick),
        .busy       (busy),
        .done       (done)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] expQ[$];
    int         compared = 0;
    int         mismatched = 0;
    int         edgeNum = 0;

    // Reference model: tracks how many enabled cycles remain until the next event
    longint     mP;
    longint     mRemain;
    logic [1:0] mModeQ;
    logic       mCounting;
    logic       mSlow;
    logic       mTick;
    logic       mBusy;
    logic       mDone;

    task automatic modelStep();
        if (reset) begin
            mP        = longint'(DEF_P);
            mRemain   = mP + 1;
            mModeQ    = mode;
            mCounting = (mode != 2'b10);
            mSlow     = 1'b0;
            mTick     = 1'b0;
            mBusy     = 1'b0;
            mDone     = 1'b0;
        end else if (period_load) begin
            mP      = longint'(period_in);
            mRemain = mP + 1;
            mTick   = 1'b0;
        end else if (mode != mModeQ) begin
            mModeQ    = mode;
            mRemain   = mP + 1;
            mCounting = (mode != 2'b10);
            mSlow     = 1'b0;
            mTick     = 1'b0;
            mBusy     = 1'b0;
            mDone     = 1'b0;
        end else if (start && (mModeQ == 2'b10)) begin
            mRemain   = mP + 1;
            mCounting = 1'b1;
            mBusy     = 1'b1;
            mDone     = 1'b0;
            mTick     = 1'b0;
        end else if (enable && mCounting) begin
            mRemain = mRemain - 1;
            if (mRemain == 0) begin
                mRemain = mP + 1;
                mTick   = 1'b1;
                if (mModeQ == 2'b00 || mModeQ == 2'b11) mSlow = ~mSlow;
                if (mModeQ == 2'b10) begin
                    mCounting = 1'b0;
                    mBusy     = 1'b0;
                    mDone     = 1'b1;
                end
            end else begin
                mTick = 1'b0;
            end
        end else begin
            mTick = 1'b0;
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic applyStimulus(input logic r, input logic en, input logic [1:0] m,
                                 input logic pl, input logic [WIDTH-1:0] pin,
                                 input logic st);
        @(negedge clk);
        reset       = r;
        enable      = en;
        mode        = m;
        period_load = pl;
        period_in   = pin;
        start       = st;
        modelStep();
        expQ.push_back({mSlow, mTick, mBusy, mDone});
    endtask

    task automatic runCycles(input int n, input logic en, input logic [1:0] m);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, en, m, 1'b0, '0, 1'b0);
    endtask

    task automatic checkOutput(input logic [3:0] expected);
        compared++;
        if ({slow_clk, tick, busy, done} !== expected) begin
            mismatched++;
            $display("[TB] FAIL outputs@edge%0d: slow/tick/busy/done got %b required %b",
                     edgeNum, {slow_clk, tick, busy, done}, expected);
        end
    endtask

    // Monitor: compare after every edge that has a queued expectation
    initial begin
        forever begin
            @(posedge clk);
            edgeNum++;
            #1;
            if (expQ.size() != 0) checkOutput(expQ.pop_front());
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        reset = 1'b0; enable = 1'b0; mode = 2'b00;
        period_load = 1'b0; period_in = '0; start = 1'b0;

        $display("[TB] reset and free-running SQUARE");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, '0, 1'b0);
        runCycles(14, 1'b1, 2'b00);

        $display("[TB] PULSE with enable gap");
        runCycles(1, 1'b1, 2'b01);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 32'd4, 1'b0);
        runCycles(7, 1'b1, 2'b01);
        runCycles(3, 1'b0, 2'b01);
        runCycles(12, 1'b1, 2'b01);

        $display("[TB] reload mid-interval");
        runCycles(1, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'd9, 1'b0);
        runCycles(2, 1'b1, 2'b00);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 32'd1, 1'b0);
        runCycles(8, 1'b1, 2'b00);

        $display("[TB] ONESHOT basic, retrigger and mode change");
        runCycles(1, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, 32'd5, 1'b0);
        runCycles(3, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, '0, 1'b1);
        runCycles(9, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, '0, 1'b1);
        runCycles(2, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, '0, 1'b1);
        runCycles(1, 1'b1, 2'b10);
        runCycles(12, 1'b1, 2'b00);

        $display("[TB] reset dominance");
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 32'd7, 1'b1);
        runCycles(6, 1'b1, 2'b10);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, '0, 1'b1);
        runCycles(6, 1'b1, 2'b10);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       en;
            logic       pl;
            logic       st;
            logic [1:0] m;
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 4) != 0);
            pl = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 9) == 0);
            m  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : mode;
            applyStimulus(r, en, m, pl, WIDTH'($urandom_range(0, 6)), st);
        end

        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
